// File: rtl/sub2_ctrl_pkg.sv
// Shared types and constants for the sub2 coefficient sequencer.
package sub2_ctrl_pkg;

    localparam int unsigned N_A_DEF = 5;
    localparam int unsigned N_B_DEF = 3;
    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned AW_DEF  = 4;

    localparam int unsigned ADDR_A_BASE = 0;
    localparam int unsigned ADDR_B_BASE = 8;

    typedef logic [DW_DEF-1:0] coef_t;
    typedef coef_t [N_A_DEF-1:0] coef_a_t;
    typedef coef_t [N_B_DEF-1:0] coef_b_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        ACK
    } state_e;

endpackage

// File: rtl/sub2_param_bank.sv
// Shadow/active coefficient register pair: address-decoded shadow writes,
// whole-set copy into the active bank on copy_i.
module sub2_param_bank
    import sub2_ctrl_pkg::*;
#(
    parameter int unsigned N_A = N_A_DEF,
    parameter int unsigned N_B = N_B_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned AW  = AW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [DW-1:0]           data_i,
    input  logic                    copy_i,
    output logic                    hit_o,
    output logic [N_A-1:0][DW-1:0]  active_a_o,
    output logic [N_B-1:0][DW-1:0]  active_b_o
);

    logic [N_A-1:0][DW-1:0] shadow_a_q, shadow_a_d, active_a_q, active_a_d;
    logic [N_B-1:0][DW-1:0] shadow_b_q, shadow_b_d, active_b_q, active_b_d;

    always_comb begin
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        hit_o      = 1'b0;
        for (int unsigned i = 0; i < N_A; i++) begin
            if (addr_i == AW'(ADDR_A_BASE + i)) begin
                hit_o = 1'b1;
                if (we_i) shadow_a_d[i] = data_i;
            end
        end
        for (int unsigned i = 0; i < N_B; i++) begin
            if (addr_i == AW'(ADDR_B_BASE + i)) begin
                hit_o = 1'b1;
                if (we_i) shadow_b_d[i] = data_i;
            end
        end
        active_a_d = copy_i ? shadow_a_q : active_a_q;
        active_b_d = copy_i ? shadow_b_q : active_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            active_a_q <= '0;
            active_b_q <= '0;
        end else begin
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            active_a_q <= active_a_d;
            active_b_q <= active_b_d;
        end
    end

    assign active_a_o = active_a_q;
    assign active_b_o = active_b_q;

endmodule

// File: rtl/sub2_param_ctrl.sv
// Config sequencer for sub2: host writes land in shadow registers and are
// applied atomically on frame_sync (or forced after SYNC_TIMEOUT cycles).
module sub2_param_ctrl
    import sub2_ctrl_pkg::*;
#(
    parameter int unsigned N_A          = N_A_DEF,
    parameter int unsigned N_B          = N_B_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned SYNC_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [DW-1:0]           cfg_data,
    output logic                    cfg_err,
    input  logic                    commit_req,
    output logic                    commit_ack,
    output logic                    commit_busy,
    input  logic                    frame_sync,
    output logic                    cfg_pending,
    output logic                    timeout_err,
    output logic [N_A-1:0][DW-1:0]  param_a,
    output logic [N_B-1:0][DW-1:0]  param_b
);

    localparam int unsigned CW = $clog2(SYNC_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
    logic            copy;
    logic            accept;
    logic            hit;

    assign cfg_ready = (state_q == IDLE);
    assign accept    = cfg_valid && cfg_ready;

    sub2_param_bank #(
        .N_A (N_A),
        .N_B (N_B),
        .DW  (DW),
        .AW  (AW)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .we_i       (accept),
        .addr_i     (cfg_addr),
        .data_i     (cfg_data),
        .copy_i     (copy),
        .hit_o      (hit),
        .active_a_o (param_a),
        .active_b_o (param_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        copy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = WAIT_SYNC;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                end
            end
            WAIT_SYNC: begin
                // Counter holds at the forced-apply value instead of wrapping.
                if (frame_sync) begin
                    copy    = 1'b1;
                    state_d = ACK;
                end else if (cnt_q == CW'(SYNC_TIMEOUT - 1)) begin
                    copy    = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d  = accept && !hit;
        pend_d = copy ? 1'b0 : ((accept && hit) ? 1'b1 : pend_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign commit_ack  = (state_q == ACK);
    assign commit_busy = (state_q != IDLE);
    assign cfg_pending = pend_q;
    assign timeout_err = tmo_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_sub2_param_ctrl.sv
// Directed bench for sub2_param_ctrl: vector table plus hand-written commit sequences.
module tb_sub2_param_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, cfg_valid, cfg_ready, cfg_err;
    logic            commit_req, commit_ack, commit_busy, frame_sync;
    logic            cfg_pending, timeout_err;
    logic [3:0]      cfg_addr;
    logic [7:0]      cfg_data;
    logic [4:0][7:0] param_a;
    logic [2:0][7:0] param_b;

    int nvec  = 0;
    int nfail = 0;

    sub2_param_ctrl #(
        .N_A          (5),
        .N_B          (3),
        .DW           (8),
        .AW           (4),
        .SYNC_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .commit_busy (commit_busy),
        .frame_sync  (frame_sync),
        .cfg_pending (cfg_pending),
        .timeout_err (timeout_err),
        .param_a     (param_a),
        .param_b     (param_b)
    );

    typedef struct {
        logic        r, v;
        logic [3:0]  ad;
        logic [7:0]  d;
        logic        c, f;
        logic        rdy, err, ack, busy, pend, tmo;
        logic [39:0] a;
        logic [23:0] b;
    } vec_t;

    function automatic vec_t mk(input logic r, v, input logic [3:0] ad, input logic [7:0] d,
                                input logic c, f, rdy, err, ack, busy, pend, tmo,
                                input logic [39:0] a, input logic [23:0] b);
        vec_t x;
        x.r = r; x.v = v; x.ad = ad; x.d = d; x.c = c; x.f = f;
        x.rdy = rdy; x.err = err; x.ack = ack; x.busy = busy; x.pend = pend; x.tmo = tmo;
        x.a = a; x.b = b;
        return x;
    endfunction

    task automatic cyc(input logic r, v, input logic [3:0] ad, input logic [7:0] d, input logic c, f);
        rst = r; cfg_valid = v; cfg_addr = ad; cfg_data = d; commit_req = c; frame_sync = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic rdy, err, ack, busy, pend, tmo,
                           input logic [39:0] a, input logic [23:0] b);
        chk({nm, ".ready"},   64'(cfg_ready),   64'(rdy));
        chk({nm, ".err"},     64'(cfg_err),     64'(err));
        chk({nm, ".ack"},     64'(commit_ack),  64'(ack));
        chk({nm, ".busy"},    64'(commit_busy), 64'(busy));
        chk({nm, ".pending"}, 64'(cfg_pending), 64'(pend));
        chk({nm, ".tmo"},     64'(timeout_err), 64'(tmo));
        chk({nm, ".param_a"}, 64'(param_a),     64'(a));
        chk({nm, ".param_b"}, 64'(param_b),     64'(b));
    endtask

    localparam logic [39:0] A1 = 40'h55_00_00_00_11;
    localparam logic [23:0] B1 = 24'h00_B1_00;
    localparam logic [39:0] A2 = 40'h55_00_7E_00_11;
    localparam logic [39:0] A3 = 40'h55_33_7E_00_11;
    localparam logic [23:0] B2 = 24'h00_B1_5A;

    vec_t tbl[18];

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        commit_req = 1'b0; frame_sync = 1'b0;

        //             r  v  ad     d      c  f  rdy err ack busy pend tmo a   b
        tbl[0]  = mk(1, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, '0, '0);
        tbl[1]  = mk(1, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, '0, '0);
        tbl[2]  = mk(0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, '0, '0);
        tbl[3]  = mk(0, 1, 4'h0, 8'h11, 0, 0, 1, 0, 0, 0, 1, 0, '0, '0);
        tbl[4]  = mk(0, 1, 4'h4, 8'h55, 0, 0, 1, 0, 0, 0, 1, 0, '0, '0);
        tbl[5]  = mk(0, 1, 4'h9, 8'hB1, 0, 0, 1, 0, 0, 0, 1, 0, '0, '0);
        tbl[6]  = mk(0, 0, 4'h0, 8'h00, 1, 0, 0, 0, 0, 1, 1, 0, '0, '0);
        tbl[7]  = mk(0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, '0, '0);
        tbl[8]  = mk(0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, '0, '0);
        tbl[9]  = mk(0, 0, 4'h0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 0, A1, B1);
        tbl[10] = mk(0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, A1, B1);
        tbl[11] = mk(0, 1, 4'h5, 8'hAA, 0, 0, 1, 1, 0, 0, 0, 0, A1, B1);
        tbl[12] = mk(0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, A1, B1);
        tbl[13] = mk(0, 1, 4'hF, 8'hCC, 0, 0, 1, 1, 0, 0, 0, 0, A1, B1);
        tbl[14] = mk(0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, A1, B1);
        tbl[15] = mk(0, 0, 4'h0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, A1, B1);
        tbl[16] = mk(0, 0, 4'h0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 0, A1, B1);
        tbl[17] = mk(0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, A1, B1);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].ad, tbl[i].d, tbl[i].c, tbl[i].f);
            chk_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].err, tbl[i].ack,
                    tbl[i].busy, tbl[i].pend, tbl[i].tmo, tbl[i].a, tbl[i].b);
        end

        // Write coincident with commit, then a host write stalled across WAIT_SYNC/ACK
        cyc(0, 1, 4'h2, 8'h7E, 1, 0); chk_out("wc.enter", 0, 0, 0, 1, 1, 0, A1, B1);
        cyc(0, 1, 4'h3, 8'h33, 0, 0); chk_out("wc.stall", 0, 0, 0, 1, 1, 0, A1, B1);
        cyc(0, 1, 4'h3, 8'h33, 0, 1); chk_out("wc.ack",   0, 0, 1, 1, 0, 0, A2, B1);
        cyc(0, 1, 4'h3, 8'h33, 0, 0); chk_out("wc.idle",  1, 0, 0, 0, 0, 0, A2, B1);
        cyc(0, 1, 4'h3, 8'h33, 0, 0); chk_out("wc.wr",    1, 0, 0, 0, 1, 0, A2, B1);
        // frame_sync in the sampling cycle must not complete the commit
        cyc(0, 0, 4'h0, 8'h00, 1, 1); chk_out("fs.ign",   0, 0, 0, 1, 1, 0, A2, B1);
        cyc(0, 0, 4'h0, 8'h00, 0, 1); chk_out("fs.ack",   0, 0, 1, 1, 0, 0, A3, B1);
        cyc(0, 0, 4'h0, 8'h00, 0, 0); chk_out("fs.idle",  1, 0, 0, 0, 0, 0, A3, B1);

        // Timeout: forced apply on the 8th edge in WAIT_SYNC
        cyc(0, 1, 4'h8, 8'h5A, 0, 0); chk_out("to.wr",    1, 0, 0, 0, 1, 0, A3, B1);
        cyc(0, 0, 4'h0, 8'h00, 1, 0); chk_out("to.enter", 0, 0, 0, 1, 1, 0, A3, B1);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 4'h0, 8'h00, 0, 0);
            chk_out($sformatf("to.wait%0d", i), 0, 0, 0, 1, 1, 0, A3, B1);
        end
        cyc(0, 0, 4'h0, 8'h00, 0, 0); chk_out("to.ack",   0, 0, 1, 1, 0, 1, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 0, 0); chk_out("to.idle",  1, 0, 0, 0, 0, 1, A3, B2);
        // New commit clears timeout_err; commit_req held re-enters after ACK
        cyc(0, 0, 4'h0, 8'h00, 1, 0); chk_out("hc.enter", 0, 0, 0, 1, 0, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 1, 1); chk_out("hc.ack",   0, 0, 1, 1, 0, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 1, 0); chk_out("hc.idle",  1, 0, 0, 0, 0, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 1, 0); chk_out("hc.again", 0, 0, 0, 1, 0, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 0, 1); chk_out("hc.ack2",  0, 0, 1, 1, 0, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 0, 0); chk_out("hc.idle2", 1, 0, 0, 0, 0, 0, A3, B2);

        // Reset during WAIT_SYNC aborts and discards the shadow
        cyc(0, 1, 4'h0, 8'h99, 0, 0); chk_out("rs.wr",    1, 0, 0, 0, 1, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 1, 0); chk_out("rs.enter", 0, 0, 0, 1, 1, 0, A3, B2);
        cyc(0, 0, 4'h0, 8'h00, 0, 0); chk_out("rs.hold",  0, 0, 0, 1, 1, 0, A3, B2);
        cyc(1, 0, 4'h0, 8'h00, 0, 0); chk_out("rs.rst",   1, 0, 0, 0, 0, 0, '0, '0);
        cyc(0, 0, 4'h0, 8'h00, 1, 0); chk_out("rs.c",     0, 0, 0, 1, 0, 0, '0, '0);
        cyc(0, 0, 4'h0, 8'h00, 0, 1); chk_out("rs.ack",   0, 0, 1, 1, 0, 0, '0, '0);
        cyc(0, 0, 4'h0, 8'h00, 0, 0); chk_out("rs.idle",  1, 0, 0, 0, 0, 0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/sub2_param_ctrl.md
Name: sub2_param_ctrl

Overview:
- Configuration sequencer for the sub2 datapath. Owns the param_a_0..4 and param_b_0..2 coefficient inputs.
- Software writes coefficients into shadow registers through a valid/ready write port. A commit request copies all shadow values into the active registers atomically, on the datapath's frame boundary (frame_sync), so the datapath never sees a half-updated set.
- Sits between the host config bus and the sub2 instance.

Parameters:
- N_A, 5, number of param_a coefficients
- N_B, 3, number of param_b coefficients
- DW, 8, coefficient width
- AW, 4, config address width
- SYNC_TIMEOUT, 255, max cycles spent in WAIT_SYNC before a forced apply (must be ≥ 2)

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- cfg_valid  input  1  config write request
- cfg_ready  output  1  write accepted when valid&&ready
- cfg_addr  input  AW  coefficient address
- cfg_data  input  DW  coefficient value
- cfg_err  output  1  one-cycle pulse: accepted write to an unmapped address
- commit_req  input  1  request to apply the shadow set; level, sampled in IDLE
- commit_ack  output  1  one-cycle pulse: the new set is visible on the outputs
- commit_busy  output  1  high in WAIT_SYNC and ACK
- frame_sync  input  1  datapath frame-boundary strobe
- cfg_pending  output  1  shadow differs from active (any write since last apply)
- timeout_err  output  1  sticky: last apply was forced by timeout
- param_a  output  [N_A-1:0][DW-1:0]  active coefficients to sub2 param_a_0..4
- param_b  output  [N_B-1:0][DW-1:0]  active coefficients to sub2 param_b_0..2

Behaviour:
- Reset (clk edge with rst=1):
  - Shadow and active registers = 0; param_a and param_b = 0.
  - State = IDLE; cfg_ready=1; cfg_err=0; commit_ack=0; commit_busy=0; cfg_pending=0; timeout_err=0; timeout counter=0.
  - rst mid-commit aborts the commit with no ack, and all shadow contents are lost.
- Address map:
  - 0..N_A-1 → shadow_a[addr].
  - 8..8+N_B-1 → shadow_b[addr-8].
  - Any other address: write is still accepted (handshake completes), no register changes, cfg_err pulses the next cycle.
- cfg_ready = (state==IDLE). Writes stall during WAIT_SYNC and ACK.
- A mapped write updates the shadow on that edge and sets cfg_pending.
- State machine:
  - IDLE: if commit_req=1 → WAIT_SYNC, clear the timeout counter, clear timeout_err.
    - A write accepted in the same cycle as commit_req lands in the shadow and is included in the commit.
  - WAIT_SYNC: increments the counter every cycle.
    - frame_sync=1 → copy all shadow to active on this edge, clear cfg_pending, → ACK.
    - frame_sync is ignored in the cycle commit_req is sampled in IDLE. Only strobes seen while in WAIT_SYNC count.
    - Counter == SYNC_TIMEOUT-1 with no frame_sync → same copy, set timeout_err, → ACK.
  - ACK: commit_ack=1 for exactly one cycle, → IDLE. The new param values are visible in this same cycle.
- Latency:
  - commit_req sampled at edge T → WAIT_SYNC from T+1.
  - frame_sync high at edge T+k (k≥1) → outputs and commit_ack valid after edge T+k.
  - Minimum commit-to-ack is 2 cycles.
- Commit with cfg_pending=0 still runs the full sequence and acks. Active values are unchanged.
- commit_req held high: after ACK → IDLE, it re-enters WAIT_SYNC the next cycle.
- Counter width is clog2(SYNC_TIMEOUT+1). It never wraps: it saturates at the forced apply.
- param_a and param_b change only on a copy edge. They are glitch-free registered outputs.

Decomposition:
- Package sub2_ctrl_pkg holds:
  - state enum {IDLE, WAIT_SYNC, ACK};
  - address constants ADDR_A_BASE=0, ADDR_B_BASE=8;
  - typedefs coef_t = logic[DW-1:0], coef_a_t = coef_t[N_A-1:0], coef_b_t = coef_t[N_B-1:0].
- Natural sub-module: sub2_param_bank, the shadow+active register pair with write decode and a copy strobe. The FSM and timeout logic stay in the top.
- The top instantiates the bank. The integrating parent connects param_a[i]→sub2.param_a_i.

Test Plan:
- Reset then idle: hold rst 2 cycles → all param outputs 0, cfg_ready=1, cfg_pending=0, no ack.
- Write addr 0=0x11, 4=0x55, 9=0xB1, then commit_req; frame_sync 3 cycles later → param_a[0]=0x11, param_a[4]=0x55, param_b[1]=0xB1 exactly in the commit_ack cycle; outputs unchanged before it; cfg_pending 1→0.
- Write to addr 5 and addr 15 → both handshakes complete, cfg_err pulses twice, shadow unchanged, cfg_pending stays 0.
- Write addr 2=0x7E in the same cycle as commit_req → 0x7E is included in the applied set; cfg_ready=0 during WAIT_SYNC; a host write attempted then stalls until after ACK.
- No frame_sync with SYNC_TIMEOUT=8 → forced apply 8 cycles after entering WAIT_SYNC, timeout_err=1, ack pulses; next commit_req clears timeout_err.
- rst asserted in WAIT_SYNC → no ack, outputs stay at old values then go to 0 after the reset edge, state IDLE.
